// File: rtl/lab1_serial_alu.sv
// Bit-serial ALU: one slice per clock, LSB first, carry kept in a flop between bits.
// Optional ALU_ZERO_FLAG_EN adds a registered result-zero flag z.
module lab1_serial_alu #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c,
   input  logic [1:0]       aluctr,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic [1:0]       dbg_state,
   output logic             e
`ifdef ALU_ZERO_FLAG_EN
   ,
   output logic             z
`endif
);

   // Handshake: start is a request accepted only in IDLE; done is a one-cycle
   // pulse marking d/e (and z) valid; busy is high exactly while bits are processed.
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   localparam logic [1:0]       OP_AND = 2'b00;
   localparam logic [1:0]       OP_OR  = 2'b01;
   localparam logic [1:0]       OP_SUB = 2'b11;
   localparam logic [CNT_W-1:0] LAST   = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             cy;
   logic [WIDTH-1:0] ra, rb;
   logic [1:0]       op;

   logic             ai, bi, sum_bit, cy_next, res_bit;
   logic [WIDTH-1:0] d_next;

   always_comb begin
      ai      = ra[0];
      bi      = (op == OP_SUB) ? ~rb[0] : rb[0];
      sum_bit = ai ^ bi ^ cy;
      cy_next = (ai & bi) | (ai & cy) | (bi & cy);
      case (op)
         OP_AND:  res_bit = ai & bi;
         OP_OR:   res_bit = ai | bi;
         default: res_bit = sum_bit;
      endcase
      d_next = {res_bit, d[WIDTH-1:1]};
   end

   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         cy    <= 1'b0;
         ra    <= '0;
         rb    <= '0;
         op    <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         d     <= '0;
         e     <= 1'b0;
`ifdef ALU_ZERO_FLAG_EN
         z     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  ra    <= a;
                  rb    <= b;
                  cy    <= c;
                  op    <= aluctr;
                  d     <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
`ifdef ALU_ZERO_FLAG_EN
                  z     <= 1'b0;
`endif
                  state <= RUN;
               end
            end
            RUN: begin
               d   <= d_next;
               ra  <= ra >> 1;
               rb  <= rb >> 1;
               cnt <= cnt + 1'b1;
               // Logic ops keep the carry flop at its initial c value.
               if (op[1]) cy <= cy_next;
               if (cnt == LAST) begin
                  e     <= op[1] & cy_next;
                  busy  <= 1'b0;
                  done  <= 1'b1;
`ifdef ALU_ZERO_FLAG_EN
                  z     <= (d_next == '0);
`endif
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lab1_serial_alu.sv
// Self-checking bench for lab1_serial_alu (WIDTH=4) with an expected-result queue.
// Builds with or without ALU_ZERO_FLAG_EN.
module tb_lab1_serial_alu;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a = '0, b = '0;
   logic         c = 1'b0;
   logic [1:0]   aluctr = 2'b00;
   logic         busy, done, e;
   logic [W-1:0] d;
   logic [1:0]   dbg_state;
`ifdef ALU_ZERO_FLAG_EN
   logic         z;
`endif

   int total = 0;
   int bad   = 0;

   // entry = {z, e, d}
   logic [W+1:0] exp_q[$];

   lab1_serial_alu #(.WIDTH(W), .CNT_W(3)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c(c), .aluctr(aluctr),
      .busy(busy), .done(done), .d(d), .dbg_state(dbg_state), .e(e)
`ifdef ALU_ZERO_FLAG_EN
      , .z(z)
`endif
   );

   always #5 clk = ~clk;

   // Reference: whole-word arithmetic, independent of the per-bit datapath.
   function automatic logic [W+1:0] alu_model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                              input logic tc, input logic [1:0] top);
      logic [W:0]   s;
      logic [W-1:0] nb;
      nb = ~tb;
      case (top)
         2'b00:   s = {1'b0, ta & tb};
         2'b01:   s = {1'b0, ta | tb};
         2'b10:   s = {1'b0, ta} + {1'b0, tb} + (W+1)'(tc);
         default: s = {1'b0, ta} + {1'b0, nb} + (W+1)'(tc);
      endcase
      return {(s[W-1:0] == '0), s};
   endfunction

   // Drive one start pulse; returns at the negedge of the cycle after the start edge.
   task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                           input logic tc, input logic [1:0] top, input bit push);
      @(negedge clk);
      a = ta; b = tb; c = tc; aluctr = top; start = 1'b1;
      if (push) exp_q.push_back(alu_model(ta, tb, tc, top));
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   // cyc = k while in the cycle following edge T+k (T = start edge); bounded wait.
   task automatic wait_done(input int c0, output int cyc, output int busy_cnt);
      cyc = c0;
      busy_cnt = 0;
      while (!done && cyc < 40) begin
         if (busy) busy_cnt++;
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if ({busy, done, d, e, dbg_state} !== '0) begin
         bad++;
         $display("FAIL reset: busy=%b done=%b d=%b e=%b state=%0d, need all 0",
                  busy, done, d, e, dbg_state);
      end
`ifdef ALU_ZERO_FLAG_EN
      total++;
      if (z !== 1'b0) begin bad++; $display("FAIL reset_z: z=%b need 0", z); end
`endif
      rst = 1'b0;
   endtask

   task automatic test_add_latency;
      int cyc, bc;
      logic [W+1:0] ex;
      start_op(4'b0111, 4'b0101, 1'b0, 2'b10, 1'b1);
      wait_done(0, cyc, bc);
      ex = exp_q.pop_front();
      total++;
      if (cyc !== W) begin bad++; $display("FAIL add_latency: cycles=%0d need %0d", cyc, W); end
      total++;
      if (bc !== W) begin bad++; $display("FAIL add_busy: busy cycles=%0d need %0d", bc, W); end
      total++;
      if ({e, d} !== ex[W:0] || ex[W:0] !== 5'b01100) begin
         bad++; $display("FAIL add_result: e=%b d=%b need e=0 d=1100", e, d);
      end
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL done_pulse: done=%b busy=%b one cycle later, need 0 0", done, busy);
      end
   endtask

   task automatic test_sub;
      int cyc, bc;
      logic [W+1:0] ex;
      start_op(4'b0011, 4'b0101, 1'b1, 2'b11, 1'b1);
      wait_done(0, cyc, bc);
      ex = exp_q.pop_front();
      total++;
      if ({e, d} !== ex[W:0]) begin
         bad++; $display("FAIL sub_neg: e=%b d=%b need e=%b d=%b", e, d, ex[W], ex[W-1:0]);
      end
      start_op(4'b0101, 4'b0011, 1'b1, 2'b11, 1'b1);
      wait_done(0, cyc, bc);
      ex = exp_q.pop_front();
      total++;
      if ({e, d} !== ex[W:0]) begin
         bad++; $display("FAIL sub_pos: e=%b d=%b need e=%b d=%b", e, d, ex[W], ex[W-1:0]);
      end
   endtask

   task automatic test_wrap_and;
      int cyc, bc;
      logic [W+1:0] ex;
      start_op(4'b1111, 4'b0001, 1'b0, 2'b10, 1'b1);
      wait_done(0, cyc, bc);
      ex = exp_q.pop_front();
      total++;
      if ({e, d} !== ex[W:0]) begin
         bad++; $display("FAIL add_wrap: e=%b d=%b need e=%b d=%b", e, d, ex[W], ex[W-1:0]);
      end
`ifdef ALU_ZERO_FLAG_EN
      total++;
      if (z !== ex[W+1]) begin bad++; $display("FAIL wrap_z: z=%b need %b", z, ex[W+1]); end
`endif
      start_op(4'b1100, 4'b1010, 1'b1, 2'b00, 1'b1);
`ifdef ALU_ZERO_FLAG_EN
      total++;
      if (z !== 1'b0) begin bad++; $display("FAIL z_clear_on_start: z=%b need 0", z); end
`endif
      wait_done(0, cyc, bc);
      ex = exp_q.pop_front();
      total++;
      if ({e, d} !== ex[W:0]) begin
         bad++; $display("FAIL and_cin: e=%b d=%b need e=%b d=%b", e, d, ex[W], ex[W-1:0]);
      end
`ifdef ALU_ZERO_FLAG_EN
      total++;
      if (z !== ex[W+1]) begin bad++; $display("FAIL and_z: z=%b need %b", z, ex[W+1]); end
`endif
   endtask

   task automatic test_ignore_start;
      int cyc, bc, extra;
      logic [W+1:0] ex;
      start_op(4'b1001, 4'b0100, 1'b0, 2'b01, 1'b1);
      @(negedge clk);
      a = 4'b0000; b = 4'b0000; aluctr = 2'b00; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a = 4'b1111; b = 4'b1111;
      wait_done(2, cyc, bc);
      ex = exp_q.pop_front();
      total++;
      if (cyc !== W) begin bad++; $display("FAIL or_latency: cycles=%0d need %0d", cyc, W); end
      total++;
      if ({e, d} !== ex[W:0]) begin
         bad++; $display("FAIL or_result: e=%b d=%b need e=%b d=%b", e, d, ex[W], ex[W-1:0]);
      end
      extra = 0;
      repeat (6) begin
         @(negedge clk);
         if (done || busy || {e, d} !== ex[W:0]) extra++;
      end
      total++;
      if (extra !== 0) begin
         bad++; $display("FAIL idle_hold: %0d bad idle cycles (d=%b e=%b), need 0", extra, d, e);
      end
   endtask

   task automatic test_reset_mid;
      int cyc, bc, seen;
      logic [W+1:0] ex;
      start_op(4'b0110, 4'b0011, 1'b0, 2'b10, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++;
      if ({busy, done, d, e, dbg_state} !== '0) begin
         bad++; $display("FAIL mid_reset: busy=%b done=%b d=%b e=%b state=%0d, need all 0",
                         busy, done, d, e, dbg_state);
      end
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (done) seen++;
      end
      total++;
      if (seen !== 0) begin bad++; $display("FAIL no_done_after_reset: pulses=%0d need 0", seen); end
      start_op(4'b0001, 4'b0001, 1'b0, 2'b10, 1'b1);
      wait_done(0, cyc, bc);
      ex = exp_q.pop_front();
      total++;
      if ({e, d} !== ex[W:0] || cyc !== W) begin
         bad++; $display("FAIL post_reset_add: e=%b d=%b cyc=%0d need e=%b d=%b cyc=%0d",
                         e, d, cyc, ex[W], ex[W-1:0], W);
      end
   endtask

   task automatic test_random;
      int cyc, bc, errs;
      logic [W+1:0] ex;
      logic [W-1:0] ra, rb;
      logic rc;
      logic [1:0] rop;
      errs = 0;
      for (int i = 0; i < 48; i++) begin
         ra  = W'($urandom_range(0, 15));
         rb  = W'($urandom_range(0, 15));
         rc  = 1'($urandom_range(0, 1));
         rop = 2'($urandom_range(0, 3));
         start_op(ra, rb, rc, rop, 1'b1);
         a = W'($urandom_range(0, 15));
         b = W'($urandom_range(0, 15));
         wait_done(0, cyc, bc);
         ex = exp_q.pop_front();
         total++;
`ifdef ALU_ZERO_FLAG_EN
         if ({z, e, d} !== ex || cyc !== W) begin
`else
         if ({e, d} !== ex[W:0] || cyc !== W) begin
`endif
            bad++; errs++;
            if (errs <= 8)
               $display("FAIL random[%0d] op=%b a=%b b=%b c=%b: e=%b d=%b cyc=%0d need e=%b d=%b z=%b",
                        i, rop, ra, rb, rc, e, d, cyc, ex[W], ex[W-1:0], ex[W+1]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_add_latency();
      test_sub();
      test_wrap_and();
      test_ignore_start();
      test_reset_mid();
      test_random();
      total++;
      if (exp_q.size() !== 0) begin
         bad++; $display("FAIL queue_empty: %0d left, need 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lab1_serial_alu.md
Name: lab1_serial_alu

Overview:
- Bit-serial form of the team's 4-bit ripple ALU.
- The ripple ALU chains one 1-bit slice per operand bit in space. This block instead runs one slice per clock, LSB first, and stores the carry in a flip-flop between cycles.
- Operands and opcode are loaded by a start pulse. The result appears after WIDTH cycles with a one-cycle done pulse.
- Used as the area-minimal, sequential counterpart in the lab1 datapath experiments. Its results are bit-exact against the combinational ALU.

Parameters:
- WIDTH, 4, operand/result width in bits (>=2).
- CNT_W, 3, width of the bit counter; must satisfy 2**CNT_W >= WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request; sampled only while idle.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- c  input  1  carry-in; captured on accepted start.
- aluctr  input  2  opcode; captured on accepted start.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when d/e become valid.
- d  output  WIDTH  result.
- e  output  1  carry-out (ADD/SUB), else 0.
- z  output  1  result-zero flag; present only with ALU_ZERO_FLAG_EN.

Behaviour:
- Opcodes, applied per bit slice with carry cy:
  - 00 AND: d_i = a_i & b_i.
  - 01 OR: d_i = a_i | b_i.
  - 10 ADD: d_i = a_i ^ b_i ^ cy; cy' = majority(a_i, b_i, cy).
  - 11 SUB: same as ADD with b_i inverted, i.e. A + ~B + c.
- cy is initialised from c for every opcode. It updates only for ADD/SUB. For AND/OR, e = 0.
- States: IDLE, RUN, DONE.
- Reset:
  - state = IDLE, counter = 0, carry flop = 0.
  - Operand and opcode regs = 0.
  - busy = 0, done = 0, d = 0, e = 0, z = 0.
- IDLE:
  - If start = 1 at an edge: capture a, b, c, aluctr; clear d to 0; counter = 0; go to RUN. busy rises in the next cycle.
  - If start = 0: d and e hold their last result.
- RUN:
  - Each edge processes bit index = counter.
  - The result bit is shifted into d from the MSB side (d <= {bit, d[WIDTH-1:1]}).
  - The operand regs shift right by 1 and the carry flop updates.
  - On the edge processing bit WIDTH-1: load e with the final carry (0 for AND/OR) and go to DONE.
- DONE:
  - done = 1 for exactly one cycle; busy = 0; d and e are final.
  - The next edge always goes to IDLE.
- Latency: start sampled at edge T gives done = 1 in the cycle following edge T+WIDTH. Throughput is one op per WIDTH+2 cycles.
- busy = 1 exactly in RUN (WIDTH cycles).
- start is ignored in RUN and DONE: no capture, no restart, no error.
- rst asserted mid-RUN or in DONE: next edge returns to the full reset state, and no done pulse is emitted.
- Inputs a/b/c/aluctr may change freely after the capture edge without affecting the result.
- Wrap-around: ADD/SUB results are modulo 2**WIDTH; overflow is visible only through e.
- d and e are registered outputs and carry no combinational path from inputs.

Optional Feature:
- Macro: ALU_ZERO_FLAG_EN.
- Defined:
  - Adds output z.
  - z is registered and updated on the same edge that enters DONE, with z = (final d == 0).
  - z holds until the next accepted start, which clears it to 0. Reset clears it to 0.
- Undefined: port z and its logic are absent. All other behaviour is identical.

Test Plan (WIDTH = 4):
- Reset, then ADD a=0111 b=0101 c=0 -> done pulses 4 cycles after the start edge; d=1100, e=0; busy high exactly 4 cycles.
- SUB a=0011 b=0101 c=1 -> d=1110, e=0. SUB a=0101 b=0011 c=1 -> d=0010, e=1.
- ADD a=1111 b=0001 c=0 -> d=0000, e=1; with ALU_ZERO_FLAG_EN, z=1. Then AND a=1100 b=1010 c=1 -> d=1000, e=0, z=0.
- OR a=1001 b=0100; pulse start again and change a/b in the 2nd RUN cycle -> single done, d=1101; extra start ignored; d/e hold in IDLE.
- Start ADD a=0110 b=0011, assert rst in the 3rd RUN cycle -> no done pulse; busy=0, d=0, e=0 next cycle. A new ADD a=0001 b=0001 then gives d=0010, e=0.
- Randomised sweep of all a, b, c, aluctr -> d/e match the combinational 4-bit ALU result for every vector.
